// File: rtl/voice_mixer_pkg.sv
// Shared audio-path constants and oscillator types used by the wavegen,
// voice mixer and filter stages.
package voice_mixer_pkg;

    localparam int MIX_NUM_VOICES   = 16;
    localparam int MIX_WIDTH        = 24;
    localparam int MASTER_VOL_W     = 8;
    localparam int MASTER_VOL_UNITY = 128;
    // Q1.7 gain: unity is 2^VOL_SHIFT
    localparam int MIX_VOL_SHIFT    = $clog2(MASTER_VOL_UNITY);

    typedef enum logic [1:0] {
        WAVE_SINE,
        WAVE_SAW,
        WAVE_SQUARE,
        WAVE_TRI
    } wave_t;

endpackage

// File: rtl/saturate.sv
// Signed saturation from IN_W down to OUT_W bits; sat flags a clamped value.
module saturate #(
    parameter int IN_W  = 37,
    parameter int OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    logic [IN_W-OUT_W:0] hi_bits;

    // In range exactly when all bits from OUT_W-1 upward are copies of the sign
    always_comb begin
        hi_bits = din[IN_W-1:OUT_W-1];
        dout    = din[OUT_W-1:0];
        sat     = 1'b0;
        if (!((&hi_bits) || !(|hi_bits))) begin
            sat  = 1'b1;
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Sums the enabled oscillator voices serially, applies master volume, saturates,
// and hands the sample downstream.
// Handshake: out_valid/out_ready transfer on a rising edge with both high; out is held while out_valid waits.
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = MIX_NUM_VOICES,
    parameter int WIDTH      = MIX_WIDTH,
    parameter int VOL_SHIFT  = MIX_VOL_SHIFT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sample_tick,
    input  logic signed [NUM_VOICES-1:0][WIDTH-1:0] voices,
    input  logic [NUM_VOICES-1:0]               voice_enable,
    input  logic [MASTER_VOL_W-1:0]             master_volume,
    output logic signed [WIDTH-1:0]             out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                clip,
    output logic                                overrun,
    output logic [1:0]                          state_dbg
);

    localparam int ACC_W  = WIDTH + $clog2(NUM_VOICES);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PROD_W = ACC_W + MASTER_VOL_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} state_t;

    state_t                         state, state_next;
    logic [NUM_VOICES-1:0][WIDTH-1:0] snap_voices;
    logic [NUM_VOICES-1:0]          snap_en;
    logic [MASTER_VOL_W-1:0]        snap_vol;
    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        addend;
    logic [IDX_W-1:0]               idx;
    logic signed [PROD_W-1:0]       product;
    logic signed [PROD_W-1:0]       scaled;
    logic signed [WIDTH-1:0]        sat_out;
    logic                           sat_flag;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (sample_tick)     state_next = ACCUM;
            ACCUM:   if (idx == LAST_IDX) state_next = SCALE;
            SCALE:                        state_next = OUTPUT;
            OUTPUT:  if (out_ready)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        addend = '0;
        if (snap_en[idx]) addend = ACC_W'($signed(snap_voices[idx]));
        // volume is unsigned, so it gets a zero sign bit before the signed multiply
        product = PROD_W'(acc) * PROD_W'($signed({1'b0, snap_vol}));
        scaled  = product >>> VOL_SHIFT;
    end

    saturate #(
        .IN_W  (PROD_W),
        .OUT_W (WIDTH)
    ) u_saturate (
        .din  (scaled),
        .dout (sat_out),
        .sat  (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_voices <= '0;
            snap_en     <= '0;
            snap_vol    <= '0;
            acc         <= '0;
            idx         <= '0;
            out         <= '0;
            clip        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            clip    <= 1'b0;
            // any tick outside IDLE is dropped, including the cycle OUTPUT completes
            overrun <= sample_tick && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (sample_tick) begin
                        snap_voices <= voices;
                        snap_en     <= voice_enable;
                        snap_vol    <= master_volume;
                        acc         <= '0;
                        idx         <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + addend;
                    idx <= idx + 1'b1;
                end
                SCALE: begin
                    out  <= sat_out;
                    clip <= sat_flag;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == OUTPUT);
    assign state_dbg = state;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: vector table through a scoreboard plus
// stall, overrun, snapshot and reset sequences.
module tb_voice_mixer;

  localparam int NV = 16;
  localparam int W  = 24;
  localparam int LAT_EDGES = NV + 1;  // edges after the capturing edge until out_valid (T+NV+2)

  typedef struct {
    logic [NV-1:0][W-1:0] v;
    logic [NV-1:0]        en;
    logic [7:0]           vol;
    logic [W-1:0]         exp_out;
    logic                 exp_clip;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_tick = 1'b0;
  logic                 out_ready = 1'b1;
  logic [NV-1:0][W-1:0] voices = '0;
  logic [NV-1:0]        voice_enable = '0;
  logic [7:0]           master_volume = '0;
  logic signed [W-1:0]  out;
  logic                 out_valid;
  logic                 clip;
  logic                 overrun;
  logic [1:0]           state_dbg;

  int checks = 0;
  int errors = 0;
  int valid_rises = 0;
  int overrun_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_clip_q[$];
  vec_t         vecs[16];

  voice_mixer dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .voices        (voices),
    .voice_enable  (voice_enable),
    .master_volume (master_volume),
    .out           (out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .clip          (clip),
    .overrun       (overrun),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic logic [NV-1:0][W-1:0] fill(input logic [W-1:0] val);
    logic [NV-1:0][W-1:0] f;
    for (int i = 0; i < NV; i++) f[i] = val;
    return f;
  endfunction

  // Reference: exact sum, multiply, floor shift, clamp -> {clip, out}
  function automatic logic [W:0] model(input logic [NV-1:0][W-1:0] v, input logic [NV-1:0] en,
                                        input logic [7:0] vol);
    longint sum;
    longint p;
    longint maxv;
    logic signed [W-1:0] s;
    sum  = 0;
    maxv = (longint'(1) <<< (W - 1)) - 1;
    for (int i = 0; i < NV; i++) begin
      if (en[i]) begin
        s = v[i];
        sum += longint'(s);
      end
    end
    p = (sum * longint'(vol)) >>> 7;
    if (p > maxv) return {1'b1, 1'b0, {(W-1){1'b1}}};
    if (p < -maxv - 1) return {1'b1, 1'b1, {(W-1){1'b0}}};
    return {1'b0, W'(p)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic         prev_valid;
    logic [W-1:0] held;
    logic [W-1:0] e;
    logic         c;
    prev_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && !prev_valid) begin
          valid_rises++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got out=%0d, expected no sample", out);
          end else begin
            e = exp_q.pop_front();
            c = exp_clip_q.pop_front();
            check("sample_out", out, e);
            check("sample_clip", W'(clip), W'(c));
          end
          held = out;
        end else begin
          check("clip_no_pulse", W'(clip), '0);
          if (out_valid) check("out_stable", out, held);
        end
        if (overrun) overrun_cnt++;
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_once();
    @(posedge clk);
    #1 sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, input int limit);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (out_valid || cyc >= limit) break;
      @(posedge clk);
      cyc++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout: got no out_valid after %0d cycles, expected one", cyc);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] e, input logic c);
    exp_q.push_back(e);
    exp_clip_q.push_back(c);
  endtask

  task automatic do_sample(input vec_t r);
    int cyc;
    voices        = r.v;
    voice_enable  = r.en;
    master_volume = r.vol;
    out_ready     = 1'b1;
    push_exp(r.exp_out, r.exp_clip);
    tick_once();
    wait_valid(cyc, 40);
    check("latency", W'(cyc), W'(LAT_EDGES));
    @(posedge clk);
    @(negedge clk);
    check("valid_drop_after_accept", W'(out_valid), '0);
  endtask

  // ---------------- test ----------------
  initial begin
    int cyc;
    int base_ov;
    int base_rises;
    logic [W:0] m;

    // stimulus table: fixed cases carry hand-computed results
    for (int i = 0; i < 16; i++) begin
      vecs[i].v = '0; vecs[i].en = '0; vecs[i].vol = 8'd128;
      vecs[i].exp_out = '0; vecs[i].exp_clip = 1'b0;
    end
    vecs[0].v[0] = W'(1000); vecs[0].v[1] = W'(2000); vecs[0].v[2] = W'(-500);
    vecs[0].en = 16'h000F; vecs[0].exp_out = W'(2500);
    vecs[1].v = fill(W'(8388607)); vecs[1].en = '1; vecs[1].vol = 8'd255;
    vecs[1].exp_out = W'(8388607); vecs[1].exp_clip = 1'b1;
    vecs[2].v = fill(W'(-8388608)); vecs[2].en = '1; vecs[2].vol = 8'd255;
    vecs[2].exp_out = W'(-8388608); vecs[2].exp_clip = 1'b1;
    vecs[3].v = fill(W'(1000)); vecs[3].en = 16'h0008; vecs[3].vol = 8'd64;
    vecs[3].exp_out = W'(500);
    vecs[4].v[3] = W'(-3); vecs[4].en = 16'h0008; vecs[4].vol = 8'd64;
    vecs[4].exp_out = W'(-2);
    vecs[5].v = fill(W'(1000)); vecs[5].en = '1; vecs[5].vol = 8'd0;
    vecs[6].v = fill(W'(8388607)); vecs[6].en = '1;
    vecs[6].exp_out = W'(8388607); vecs[6].exp_clip = 1'b1;
    vecs[7].v = fill(W'(100)); vecs[7].en = '1; vecs[7].exp_out = W'(1600);
    vecs[8].v[0] = W'(8388607); vecs[8].en = 16'h0001; vecs[8].exp_out = W'(8388607);
    vecs[9].v[15] = W'(-8388608); vecs[9].en = 16'h8000; vecs[9].exp_out = W'(-8388608);
    // random cases take their results from the model
    for (int i = 10; i < 16; i++) begin
      for (int k = 0; k < NV; k++) begin
        if (i < 13) vecs[i].v[k] = W'($urandom());
        else        vecs[i].v[k] = W'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
      end
      vecs[i].en  = 16'($urandom_range(0, 65535));
      vecs[i].vol = 8'($urandom_range(0, 255));
      m = model(vecs[i].v, vecs[i].en, vecs[i].vol);
      vecs[i].exp_out  = m[W-1:0];
      vecs[i].exp_clip = m[W];
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", out, '0);
    check("rst_valid", W'(out_valid), '0);
    check("rst_clip", W'(clip), '0);
    check("rst_overrun", W'(overrun), '0);
    check("rst_state", W'(state_dbg), '0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) do_sample(vecs[i]);

    // snapshot isolation: inputs change one cycle after the tick
    voices = vecs[0].v; voice_enable = vecs[0].en; master_volume = 8'd128;
    push_exp(W'(2500), 1'b0);
    tick_once();
    voices = fill(W'(5000)); voice_enable = '1; master_volume = 8'd200;
    wait_valid(cyc, 40);
    check("snap_latency", W'(cyc), W'(LAT_EDGES));
    @(posedge clk);
    #1;

    // stall 50 cycles with a second tick at +10
    voices = vecs[7].v; voice_enable = vecs[7].en; master_volume = vecs[7].vol;
    out_ready = 1'b0;
    push_exp(vecs[7].exp_out, vecs[7].exp_clip);
    tick_once();
    wait_valid(cyc, 40);
    #1;
    base_ov = overrun_cnt;
    base_rises = valid_rises;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1 sample_tick = (k == 10);
    end
    sample_tick = 1'b0;
    @(negedge clk);
    check("stall_still_valid", W'(out_valid), W'(1));
    check("stall_out_held", out, vecs[7].exp_out);
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("stall_overrun_once", W'(overrun_cnt - base_ov), W'(1));
    check("stall_one_sample", W'(valid_rises - base_rises), '0);
    check("stall_back_idle", W'(state_dbg), '0);

    // tick in the same cycle OUTPUT completes is an overrun, not a restart
    push_exp(vecs[0].exp_out, vecs[0].exp_clip);
    voices = vecs[0].v; voice_enable = vecs[0].en; master_volume = vecs[0].vol;
    tick_once();
    wait_valid(cyc, 40);
    #1;
    base_ov = overrun_cnt;
    base_rises = valid_rises;
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("complete_tick_overrun", W'(overrun_cnt - base_ov), W'(1));
    check("complete_tick_no_restart", W'(valid_rises - base_rises), '0);

    // reset mid-ACCUM discards the sample; a tick coincident with reset is ignored
    voices = vecs[1].v; voice_enable = vecs[1].en; master_volume = vecs[1].vol;
    base_ov = overrun_cnt;
    base_rises = valid_rises;
    tick_once();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b1;
    @(negedge clk);
    check("midrst_out", out, '0);
    check("midrst_valid", W'(out_valid), '0);
    check("midrst_clip", W'(clip), '0);
    check("midrst_overrun", W'(overrun), '0);
    @(posedge clk);
    #1 sample_tick = 1'b0;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_valid", W'(valid_rises - base_rises), '0);
    check("midrst_no_overrun", W'(overrun_cnt - base_ov), '0);
    check("midrst_idle", W'(state_dbg), '0);
    check("midrst_out_held", out, '0);

    do_sample(vecs[0]);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 16, number of oscillator outputs mixed.
REQ-002 SHALL have parameter WIDTH, default 24, sample width in bits, matching oscillator out.
REQ-003 SHALL have parameter VOL_SHIFT, default 7, volume fraction bits; master_volume 128 = unity.
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port sample_tick  in  1  one-cycle pulse per 48 kHz output sample.
REQ-007 SHALL have port voices  in  NUM_VOICES x WIDTH signed  oscillator outputs.
REQ-008 SHALL have port voice_enable  in  NUM_VOICES  per-voice include mask.
REQ-009 SHALL have port master_volume  in  8 unsigned  Q1.7 gain, 0..255 = 0..1.992.
REQ-010 SHALL have port out  out  WIDTH signed  mixed sample.
REQ-011 SHALL have port out_valid  out  1  out holds a new sample.
REQ-012 SHALL have port out_ready  in  1  downstream (DAC/I2S) accepts out.
REQ-013 SHALL have port clip  out  1  one-cycle pulse, current sample saturated.
REQ-014 SHALL have port overrun  out  1  one-cycle pulse, sample_tick dropped.

Function
REQ-015 SHALL implement FSM IDLE -> ACCUM -> SCALE -> OUTPUT -> IDLE.
REQ-016 In IDLE, on sample_tick SHALL snapshot voices, voice_enable, master_volume into registers, clear accumulator, clear index, go to ACCUM.
REQ-017 In ACCUM SHALL add one snapshot voice per cycle, index 0 upward, sign-extended to ACC_W = WIDTH + clog2(NUM_VOICES); disabled voices add 0.
REQ-018 ACCUM SHALL last exactly NUM_VOICES cycles, then go to SCALE.
REQ-019 In SCALE SHALL compute acc * volume (signed x unsigned, full width), arithmetic shift right VOL_SHIFT (floor), saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], register into out, go to OUTPUT.
REQ-020 clip SHALL pulse on the cycle out_valid first rises if saturation occurred.
REQ-021 In OUTPUT out_valid SHALL be 1 and out stable until out_ready=1; then go to IDLE the next cycle with out_valid=0.
REQ-022 Latency: sample_tick at cycle T -> out_valid=1 at T+NUM_VOICES+2 when not stalled.
REQ-023 sample_tick in ACCUM, SCALE or OUTPUT SHALL be ignored and overrun pulses the next cycle; the in-flight sample is unaffected.
REQ-024 sample_tick in the same cycle OUTPUT completes (out_ready=1) SHALL count as overrun; no back-to-back start.
REQ-025 Changes on voices/voice_enable/master_volume after the snapshot SHALL not affect the current sample.
REQ-026 out SHALL hold its last value in IDLE.

Reset
REQ-027 rst SHALL force state IDLE, out=0, out_valid=0, clip=0, overrun=0, accumulator, index and snapshots to 0.
REQ-028 rst mid-ACCUM or mid-OUTPUT SHALL discard the sample; no out_valid until a fresh sample_tick after rst deasserts.
REQ-029 sample_tick coincident with rst SHALL be ignored.

Structure
REQ-030 NUM_VOICES default, MASTER_VOL_UNITY (128) and VOL_SHIFT SHALL live in the shared constants header / protocol_pkg next to the wavegen types.
REQ-031 The FSM state enum SHALL be local to the module.
REQ-032 Saturation SHALL be one parameterised sub-module, saturate (IN_W, OUT_W), reusable by the oscillator and filter stages.

Verification
REQ-033 4 voices = 1000, 2000, -500, 0, all enabled, others disabled, vol=128, tick -> out=2500, out_valid at T+18, clip=0.
REQ-034 16 voices = 2^23-1, vol=255 -> out=8388607, clip pulse; all -2^23 -> out=-8388608, clip pulse.
REQ-035 Voices 1000 each, enable only voice 3, vol=64 -> out=500; voice -3 alone, vol=64 -> out=-2 (floor).
REQ-036 out_ready=0 for 50 cycles after out_valid, second tick at +10 -> out stable, overrun pulses once, one sample accepted.
REQ-037 Change voices one cycle after tick -> out reflects snapshot values; rst asserted mid-ACCUM -> no out_valid, all outputs 0.
